i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target (slave) with fixed 7-bit address, oversampled from the system clock.
// Receives written bytes on rx_data/rx_valid and requests read bytes via tx_req/tx_data.
module i2c_target #(
    parameter logic [6:0] OWN_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK
    } state_e;

    state_e      state_q;
    logic        scl_s1_q, scl_s2_q, scl_h_q;
    logic        sda_s1_q, sda_s2_q, sda_h_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        rw_q;
    logic        nack_q;
    logic        byte_done_q;
    logic        tx_load_q;
    logic        sda_oe_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        tx_req_q;
    logic        start_det_q;
    logic        stop_det_q;

    logic scl_rise, scl_fall, scl_high;
    logic sda_rise, sda_fall;
    logic start_c, stop_c;

    // Edges are taken between the synchronized level and its history flop.
    assign scl_rise = scl_s2_q & ~scl_h_q;
    assign scl_fall = ~scl_s2_q & scl_h_q;
    assign scl_high = scl_s2_q & scl_h_q;
    assign sda_rise = sda_s2_q & ~sda_h_q;
    assign sda_fall = ~sda_s2_q & sda_h_q;
    assign start_c  = sda_fall & scl_high;
    assign stop_c   = sda_rise & scl_high;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a true shift chain.
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            byte_done_q <= 1'b0;
            tx_load_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            tx_load_q   <= 1'b0;

            if (start_c) begin
                state_q     <= ADDR;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                start_det_q <= 1'b1;
            end else if (stop_c) begin
                state_q     <= IDLE;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                stop_det_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    ADDR, WRITE: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s2_q};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                                if (state_q == WRITE) begin
                                    rx_data_q  <= {shift_q[6:0], sda_s2_q};
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (state_q == WRITE) begin
                                sda_oe_q <= 1'b1;
                                state_q  <= WR_ACK;
                            end else if (shift_q[7:1] == OWN_ADDR) begin
                                rw_q     <= shift_q[0];
                                sda_oe_q <= 1'b1;
                                state_q  <= ADDR_ACK;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (rw_q) begin
                                tx_req_q  <= 1'b1;
                                tx_load_q <= 1'b1;
                                state_q   <= READ;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= WRITE;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= RD_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack_q <= sda_s2_q;
                        end else if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (nack_q) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= IDLE;
                            end else begin
                                tx_req_q  <= 1'b1;
                                tx_load_q <= 1'b1;
                                state_q   <= READ;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Read byte arrives one clk after tx_req; MSB goes onto the bus immediately.
                if (tx_load_q) begin
                    shift_q  <= tx_data;
                    sda_oe_q <= ~tx_data[7];
                end
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = (state_q != IDLE);
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on an open-drain SDA model,
// with pulse counters sampled on the falling clk edge.
module tb_i2c_target;

    localparam int QP = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_ctrl;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    int checks = 0;
    int errors = 0;

    int rxv_cnt = 0;
    int txr_cnt = 0;
    int sd_cnt  = 0;
    int pd_cnt  = 0;
    int oe_cnt  = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target #(.OWN_ADDR(7'h42)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_ctrl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always @(negedge clk) begin
        if (rx_valid)  rxv_cnt++;
        if (tx_req)    txr_cnt++;
        if (start_det) sd_cnt++;
        if (stop_det)  pd_cnt++;
        if (sda_oe)    oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic qp();
        repeat (QP) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_ctrl = 1'b1; qp();
        scl_ctrl = 1'b1; qp();
        sda_ctrl = 1'b0; qp();
        scl_ctrl = 1'b0; qp();
    endtask

    task automatic stop_cond();
        sda_ctrl = 1'b0; qp();
        scl_ctrl = 1'b1; qp();
        sda_ctrl = 1'b1; qp();
        qp();
    endtask

    task automatic write_bit(input logic b);
        sda_ctrl = b; qp();
        scl_ctrl = 1'b1; qp(); qp();
        scl_ctrl = 1'b0; qp();
    endtask

    task automatic read_bit(output logic b, output logic oe);
        sda_ctrl = 1'b1; qp();
        scl_ctrl = 1'b1; qp();
        b  = sda_line;
        oe = sda_oe;
        qp();
        scl_ctrl = 1'b0; qp();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_line, output logic ack_oe);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_line, ack_oe);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b, oe;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b, oe);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sda_oe"},    sda_oe,    1'b0);
        check({pfx, "_rx_data"},   rx_data,   8'h00);
        check({pfx, "_rx_valid"},  rx_valid,  1'b0);
        check({pfx, "_tx_req"},    tx_req,    1'b0);
        check({pfx, "_busy"},      busy,      1'b0);
        check({pfx, "_start_det"}, start_det, 1'b0);
        check({pfx, "_stop_det"},  stop_det,  1'b0);
    endtask

    initial begin
        logic       ack, oe, b;
        logic [7:0] d;
        int rxv0, txr0, sd0, pd0, oe0;

        rst_n    = 1'b0;
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write 0xA5 to address 0x42.
        rxv0 = rxv_cnt; sd0 = sd_cnt; pd0 = pd_cnt;
        start_cond();
        write_byte(8'h84, ack, oe);
        check("wr_addr_ack_line", ack, 1'b0);
        check("wr_addr_ack_oe", oe, 1'b1);
        write_byte(8'hA5, ack, oe);
        check("wr_data_ack_line", ack, 1'b0);
        check("wr_data_ack_oe", oe, 1'b1);
        stop_cond();
        check("wr_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check("wr_rx_data", rx_data, 8'hA5);
        check("wr_start_cnt", sd_cnt - sd0, 1);
        check("wr_stop_cnt", pd_cnt - pd0, 1);
        check("wr_busy_after", busy, 1'b0);

        // Address mismatch: 0x43 is not ours.
        rxv0 = rxv_cnt; oe0 = oe_cnt;
        start_cond();
        write_byte(8'h86, ack, oe);
        check("mm_addr_nack", ack, 1'b1);
        check("mm_busy_after_9", busy, 1'b0);
        write_byte(8'h11, ack, oe);
        check("mm_data_nack", ack, 1'b1);
        stop_cond();
        check("mm_oe_cnt", oe_cnt - oe0, 0);
        check("mm_rx_valid_cnt", rxv_cnt - rxv0, 0);

        // Read two bytes: ACK the first, NACK the second.
        txr0 = txr_cnt;
        tx_data = 8'h3C;
        start_cond();
        write_byte(8'h85, ack, oe);
        check("rd_addr_ack_line", ack, 1'b0);
        tx_data = 8'hF0;
        read_byte(1'b0, d);
        check("rd_byte0", d, 8'h3C);
        read_byte(1'b1, d);
        check("rd_byte1", d, 8'hF0);
        check("rd_tx_req_cnt", txr_cnt - txr0, 2);
        check("rd_busy_after_nack", busy, 1'b0);
        check("rd_oe_after_nack", sda_oe, 1'b0);
        stop_cond();

        // Write 0x07, repeated START, read one byte.
        rxv0 = rxv_cnt; txr0 = txr_cnt; sd0 = sd_cnt; pd0 = pd_cnt;
        start_cond();
        write_byte(8'h84, ack, oe);
        write_byte(8'h07, ack, oe);
        check("sr_wr_ack", ack, 1'b0);
        tx_data = 8'h5A;
        start_cond();
        write_byte(8'h85, ack, oe);
        check("sr_addr_ack", ack, 1'b0);
        read_byte(1'b1, d);
        check("sr_rd_byte", d, 8'h5A);
        stop_cond();
        check("sr_rx_data", rx_data, 8'h07);
        check("sr_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check("sr_start_cnt", sd_cnt - sd0, 2);
        check("sr_tx_req_cnt", txr_cnt - txr0, 1);
        check("sr_stop_cnt", pd_cnt - pd0, 1);

        // Reset after 4 bits of a write data byte.
        start_cond();
        write_byte(8'h84, ack, oe);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        check("mr_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mr");
        rst_n = 1'b1;
        rxv0 = rxv_cnt;
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        read_bit(b, oe);
        check("mr_ignored_nack", b, 1'b1);
        check("mr_busy_ignored", busy, 1'b0);
        check("mr_no_rx_valid", rxv_cnt - rxv0, 0);
        stop_cond();
        start_cond();
        write_byte(8'h84, ack, oe);
        check("mr_next_addr_ack", ack, 1'b0);
        write_byte(8'h3C, ack, oe);
        check("mr_next_data_ack", ack, 1'b0);
        stop_cond();
        check("mr_next_rx_data", rx_data, 8'h3C);
        check("mr_next_rx_valid_cnt", rxv_cnt - rxv0, 1);

        // STOP after 3 bits of a write data byte.
        start_cond();
        write_byte(8'h84, ack, oe);
        rxv0 = rxv_cnt; pd0 = pd_cnt;
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        stop_cond();
        check("sp_busy", busy, 1'b0);
        check("sp_rx_valid_cnt", rxv_cnt - rxv0, 0);
        check("sp_sda_oe", sda_oe, 1'b0);
        check("sp_stop_cnt", pd_cnt - pd0, 1);
        check("sp_rx_data_kept", rx_data, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
